// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes four 4-bit glyph codes onto a 4-digit common-anode
// 7-segment display (active-low anodes and segments). The inputs are
// snapshotted once per scan frame so a digit never mixes two input values.
// Every digit slot starts with a dead-time window, with all anodes off, to
// suppress ghosting between digits.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] C,
    input  logic [3:0] D,
    input  logic [3:0] blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LIM = CW'(DEAD_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // Glyph decode to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode_glyph(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0101111;  // 'r'
            4'hB:    s = 7'b0000110;  // 'E'
            4'hC:    s = 7'b0100001;  // 'd'
            4'hD:    s = 7'b0010001;  // 'y'
            4'hE:    s = 7'b1000010;  // 'G'
            4'hF:    s = 7'b0100011;  // 'o'
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_r;
    logic [1:0]    idx_r;
    logic [3:0]    sh_a_r;
    logic [3:0]    sh_b_r;
    logic [3:0]    sh_c_r;
    logic [3:0]    sh_d_r;
    logic [3:0]    sh_blank_r;

    logic          cnt_wrap_s;
    logic          frame_start_s;
    logic          frame_end_s;
    logic [3:0]    sel_digit_s;
    logic          sel_blank_s;
    logic [3:0]    sel_an_s;
    logic [3:0]    an_nxt_s;
    logic [6:0]    seg_nxt_s;

    assign cnt_wrap_s    = (cnt_r == CNT_LAST);
    assign frame_start_s = (idx_r == 2'd0) && (cnt_r == '0);
    assign frame_end_s   = (idx_r == 2'd3) && cnt_wrap_s;

    // Slot timer and digit index; the index advances when the slot timer wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
            idx_r <= 2'd0;
        end else if (cnt_wrap_s) begin
            cnt_r <= '0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            idx_r <= idx_r;
        end
    end

    // Snapshot of all digit inputs, taken only at the start of a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a_r     <= 4'h0;
            sh_b_r     <= 4'h0;
            sh_c_r     <= 4'h0;
            sh_d_r     <= 4'h0;
            sh_blank_r <= 4'b1111;
        end else if (frame_start_s) begin
            sh_a_r     <= A;
            sh_b_r     <= B;
            sh_c_r     <= C;
            sh_d_r     <= D;
            sh_blank_r <= blank;
        end else begin
            sh_a_r     <= sh_a_r;
            sh_b_r     <= sh_b_r;
            sh_c_r     <= sh_c_r;
            sh_d_r     <= sh_d_r;
            sh_blank_r <= sh_blank_r;
        end
    end

    // Select the digit, blank bit and anode pattern for the current slot
    always_comb begin
        sel_digit_s = sh_a_r;
        sel_blank_s = 1'b1;
        sel_an_s    = 4'b1111;
        case (idx_r)
            2'd0: begin
                sel_digit_s = sh_a_r;
                sel_blank_s = sh_blank_r[3];
                sel_an_s    = 4'b0111;
            end
            2'd1: begin
                sel_digit_s = sh_b_r;
                sel_blank_s = sh_blank_r[2];
                sel_an_s    = 4'b1011;
            end
            2'd2: begin
                sel_digit_s = sh_c_r;
                sel_blank_s = sh_blank_r[1];
                sel_an_s    = 4'b1101;
            end
            2'd3: begin
                sel_digit_s = sh_d_r;
                sel_blank_s = sh_blank_r[0];
                sel_an_s    = 4'b1110;
            end
            default: begin
                sel_digit_s = sh_a_r;
                sel_blank_s = 1'b1;
                sel_an_s    = 4'b1111;
            end
        endcase
    end

    // Next display value: dark during dead time or for a blanked digit
    always_comb begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 7'b1111111;
        if (cnt_r < DEAD_LIM) begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 7'b1111111;
        end else if (sel_blank_s) begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 7'b1111111;
        end else begin
            an_nxt_s  = sel_an_s;
            seg_nxt_s = decode_glyph(sel_digit_s);
        end
    end

    // Registered display outputs and end-of-frame pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= 4'b1111;
            seg        <= 7'b1111111;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_nxt_s;
            seg        <= seg_nxt_s;
            dp         <= 1'b1;
            frame_done <= frame_end_s;
        end
    end

endmodule
